// File: rtl/tinyml_cam_scale_pkg.sv
// Shared encodings and helpers for the tinyml camera down-scaler (2 pixels per clock).
package tinyml_cam_scale_pkg;

    typedef enum logic [1:0] {
        FACTOR_1X   = 2'd0,
        FACTOR_2X   = 2'd1,
        FACTOR_4X   = 2'd2,
        FACTOR_RSVD = 2'd3
    } factor_e;

    typedef enum logic {
        MODE_NN  = 1'b0,
        MODE_AVG = 1'b1
    } mode_e;

    localparam int ACC_W_DEFAULT = 12;
    localparam int COORD_W       = 11;

    // The reserved encoding scales like 2x.
    function automatic logic [1:0] log2f(input logic [1:0] factor);
        logic [1:0] l2f;
        case (factor_e'(factor))
            FACTOR_1X: l2f = 2'd0;
            FACTOR_4X: l2f = 2'd2;
            default:   l2f = 2'd1;
        endcase
        return l2f;
    endfunction

    // Beat-phase / line-phase mask: F-1 for F in {1,2,4}.
    function automatic logic [1:0] phase_mask(input logic [1:0] l2f);
        logic [1:0] mask;
        case (l2f)
            2'd0:    mask = 2'b00;
            2'd1:    mask = 2'b01;
            default: mask = 2'b11;
        endcase
        return mask;
    endfunction

    // Half of the F*F block size, added before the divide to round to nearest.
    function automatic logic [3:0] round_const(input logic [1:0] l2f);
        logic [3:0] rnd;
        case (l2f)
            2'd1:    rnd = 4'd2;
            2'd2:    rnd = 4'd8;
            default: rnd = 4'd0;
        endcase
        return rnd;
    endfunction

endpackage

// File: rtl/tinyml_line_acc_ram.sv
// Simple dual-port line accumulator RAM with a one-cycle registered read.
module tinyml_line_acc_ram #(
    parameter int DEPTH = 270,
    parameter int WIDTH = 72,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/tinyml_cam_scale_down_nn_avg.sv
// 2PPC camera down-scaler: 1x/2x/4x in both axes, nearest-neighbour or rounded box average.
module tinyml_cam_scale_down_nn_avg
    import tinyml_cam_scale_pkg::*;
#(
    parameter int P_DEPTH        = 8,
    parameter int IN_FRAME_WIDTH = 1080,
    parameter int ACC_W          = P_DEPTH + 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           cfg_factor,
    input  logic                 cfg_mode,
    input  logic [10:0]          in_x,
    input  logic [10:0]          in_y,
    input  logic [2*P_DEPTH-1:0] in_red,
    input  logic [2*P_DEPTH-1:0] in_green,
    input  logic [2*P_DEPTH-1:0] in_blue,
    input  logic                 in_valid,
    output logic [2*P_DEPTH-1:0] out_red,
    output logic [2*P_DEPTH-1:0] out_green,
    output logic [2*P_DEPTH-1:0] out_blue,
    output logic [10:0]          out_x,
    output logic [10:0]          out_y,
    output logic                 out_valid
);

    localparam int RAM_DEPTH = IN_FRAME_WIDTH / 4;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    // Component index 0 = red, 1 = green, 2 = blue; pair index 0 = low (even) output pixel.
    typedef logic [2:0][ACC_W-1:0] pix3_t;
    typedef logic [1:0][2:0][ACC_W-1:0] pair_t;

    function automatic pix3_t add3(input pix3_t a, input pix3_t b);
        pix3_t r;
        for (int c = 0; c < 3; c++) begin
            r[c] = a[c] + b[c];
        end
        return r;
    endfunction

    logic              frame_start_s, beat_ok_s, eff_mode_s, avg_s;
    logic [1:0]        eff_factor_s, l2f_s, mask_s;
    logic              complete_s, first_line_s, last_line_s;
    logic              emit_s, wr_s, add_s;
    logic [RAM_AW-1:0] raddr_s;
    pix3_t             pix_even_s, pix_odd_s, beat_sum_s, h_lo_nxt_s, h_hi_nxt_s;
    pair_t             cur_s, rdata_s, acc_s, res_s;

    logic [1:0]        act_factor_r;
    logic              act_mode_r, frame_armed_r;
    pix3_t             h_lo_r, h_hi_r;
    logic              s1_valid_r, s1_wr_r, s1_add_r;
    pair_t             s1_data_r;
    logic [RAM_AW-1:0] s1_addr_r;
    logic [10:0]       s1_x_r, s1_y_r;
    logic [2:0]        s1_shift_r;
    logic [3:0]        s1_rnd_r;

    // Frame-start detect, effective configuration and beat/line phase decode.
    always_comb begin
        frame_start_s = in_valid && (in_x == 11'd0) && (in_y == 11'd0);
        if (frame_start_s) begin
            eff_factor_s = cfg_factor;
            eff_mode_s   = cfg_mode;
        end else begin
            eff_factor_s = act_factor_r;
            eff_mode_s   = act_mode_r;
        end
        beat_ok_s    = in_valid && (frame_armed_r || frame_start_s);
        l2f_s        = log2f(eff_factor_s);
        mask_s       = phase_mask(l2f_s);
        complete_s   = ((in_x[1:0] & mask_s) == mask_s);
        first_line_s = ((in_y[1:0] & mask_s) == 2'd0);
        last_line_s  = ((in_y[1:0] & mask_s) == mask_s);
        avg_s        = (eff_mode_s == MODE_AVG) && (l2f_s != 2'd0);
        if (l2f_s == 2'd0) begin
            emit_s = 1'b1;
        end else if (avg_s) begin
            emit_s = complete_s && last_line_s;
        end else begin
            emit_s = complete_s && first_line_s;
        end
        wr_s    = avg_s && complete_s && !last_line_s;
        add_s   = avg_s && complete_s && !first_line_s;
        raddr_s = RAM_AW'(in_x >> l2f_s);
    end

    // Horizontal select/sum: the completed output pair and the partial-sum updates.
    always_comb begin
        pix_even_s[0] = ACC_W'(in_red[P_DEPTH-1:0]);
        pix_even_s[1] = ACC_W'(in_green[P_DEPTH-1:0]);
        pix_even_s[2] = ACC_W'(in_blue[P_DEPTH-1:0]);
        pix_odd_s[0]  = ACC_W'(in_red[2*P_DEPTH-1:P_DEPTH]);
        pix_odd_s[1]  = ACC_W'(in_green[2*P_DEPTH-1:P_DEPTH]);
        pix_odd_s[2]  = ACC_W'(in_blue[2*P_DEPTH-1:P_DEPTH]);
        beat_sum_s    = add3(pix_even_s, pix_odd_s);

        case (l2f_s)
            2'd0: begin
                cur_s[0] = pix_even_s;
                cur_s[1] = pix_odd_s;
            end
            2'd1: begin
                cur_s[0] = h_lo_r;
                cur_s[1] = avg_s ? beat_sum_s : pix_even_s;
            end
            default: begin
                cur_s[0] = h_lo_r;
                cur_s[1] = avg_s ? add3(h_hi_r, beat_sum_s) : h_hi_r;
            end
        endcase

        h_lo_nxt_s = h_lo_r;
        h_hi_nxt_s = h_hi_r;
        if (l2f_s != 2'd0) begin
            case (in_x[1:0] & mask_s)
                2'd0: h_lo_nxt_s = avg_s ? beat_sum_s : pix_even_s;
                2'd1: begin
                    if ((l2f_s == 2'd2) && avg_s) begin
                        h_lo_nxt_s = add3(h_lo_r, beat_sum_s);
                    end else begin
                        h_lo_nxt_s = h_lo_r;
                    end
                end
                2'd2: h_hi_nxt_s = avg_s ? beat_sum_s : pix_even_s;
                default: h_lo_nxt_s = h_lo_r;
            endcase
        end else begin
            h_lo_nxt_s = h_lo_r;
        end
    end

    // Config latch, horizontal partial sums and stage-1 pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_factor_r  <= 2'd1;
            act_mode_r    <= 1'b0;
            frame_armed_r <= 1'b0;
            h_lo_r        <= {(3*ACC_W){1'b0}};
            h_hi_r        <= {(3*ACC_W){1'b0}};
            s1_valid_r    <= 1'b0;
            s1_wr_r       <= 1'b0;
            s1_add_r      <= 1'b0;
            s1_data_r     <= {(6*ACC_W){1'b0}};
            s1_addr_r     <= {RAM_AW{1'b0}};
            s1_x_r        <= 11'd0;
            s1_y_r        <= 11'd0;
            s1_shift_r    <= 3'd0;
            s1_rnd_r      <= 4'd0;
        end else begin
            if (frame_start_s) begin
                act_factor_r  <= cfg_factor;
                act_mode_r    <= cfg_mode;
                frame_armed_r <= 1'b1;
            end
            if (beat_ok_s) begin
                h_lo_r <= h_lo_nxt_s;
                h_hi_r <= h_hi_nxt_s;
            end
            s1_valid_r <= beat_ok_s && emit_s;
            s1_wr_r    <= beat_ok_s && wr_s;
            if (beat_ok_s && complete_s) begin
                s1_data_r  <= cur_s;
                s1_add_r   <= add_s;
                s1_addr_r  <= raddr_s;
                s1_x_r     <= in_x >> l2f_s;
                s1_y_r     <= in_y >> l2f_s;
                s1_shift_r <= avg_s ? {l2f_s, 1'b0} : 3'd0;
                s1_rnd_r   <= avg_s ? round_const(l2f_s) : 4'd0;
            end
        end
    end

    tinyml_line_acc_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (6 * ACC_W),
        .AW    (RAM_AW)
    ) u_line_acc_ram (
        .clk   (clk),
        .we    (s1_wr_r),
        .waddr (s1_addr_r),
        .wdata (acc_s),
        .re    (beat_ok_s && add_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Vertical accumulate and round; NN and 1x use zero shift and zero rounding.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 3; c++) begin
                acc_s[p][c] = s1_data_r[p][c] + (s1_add_r ? rdata_s[p][c] : {ACC_W{1'b0}});
                res_s[p][c] = (acc_s[p][c] + ACC_W'(s1_rnd_r)) >> s1_shift_r;
            end
        end
    end

    // Output register; data and coordinates hold between output beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_red   <= {(2*P_DEPTH){1'b0}};
            out_green <= {(2*P_DEPTH){1'b0}};
            out_blue  <= {(2*P_DEPTH){1'b0}};
            out_x     <= 11'd0;
            out_y     <= 11'd0;
        end else begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_red   <= {res_s[1][0][P_DEPTH-1:0], res_s[0][0][P_DEPTH-1:0]};
                out_green <= {res_s[1][1][P_DEPTH-1:0], res_s[0][1][P_DEPTH-1:0]};
                out_blue  <= {res_s[1][2][P_DEPTH-1:0], res_s[0][2][P_DEPTH-1:0]};
                out_x     <= s1_x_r;
                out_y     <= s1_y_r;
            end
        end
    end

endmodule

// File: tb/tb_tinyml_cam_scale_down_nn_avg.sv
// Self-checking bench: vector table, directed corner sequences and randomized frames vs a frame-level model.
module tb_tinyml_cam_scale_down_nn_avg;

    localparam int P     = 8;
    localparam int W     = 16;
    localparam int BEATS = W / 2;
    localparam int H     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_factor;
    logic        cfg_mode;
    logic [10:0] in_x, in_y;
    logic [15:0] in_red, in_green, in_blue;
    logic        in_valid;
    logic [15:0] out_red, out_green, out_blue;
    logic [10:0] out_x, out_y;
    logic        out_valid;

    always #5 clk = ~clk;

    tinyml_cam_scale_down_nn_avg #(
        .P_DEPTH        (P),
        .IN_FRAME_WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_factor (cfg_factor),
        .cfg_mode   (cfg_mode),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_red     (in_red),
        .in_green   (in_green),
        .in_blue    (in_blue),
        .in_valid   (in_valid),
        .out_red    (out_red),
        .out_green  (out_green),
        .out_blue   (out_blue),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_valid  (out_valid)
    );

    typedef struct {
        int          cyc;
        int          x;
        int          y;
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
    } exp_t;

    typedef struct {
        logic [1:0] factor;
        logic       mode;
        int         base;
        int         val;
        int         py;
        int         px;
        int         exp_val;
    } vec_t;

    exp_t q[$];
    int   img     [3][H][W];
    int   out_img [3][H][W];
    int   m_f = 2;
    bit   m_avg = 1'b0;
    bit   m_armed = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_out = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fac(input logic [1:0] cf);
        if (cf == 2'd0) return 1;
        if (cf == 2'd2) return 4;
        return 2;
    endfunction

    // Output pixel from the source frame using plain block arithmetic.
    function automatic int model_pix(input int c, input int oy, input int opx);
        int sum;
        if (m_f == 1) return img[c][oy][opx];
        if (!m_avg) return img[c][m_f*oy][m_f*opx];
        sum = 0;
        for (int i = 0; i < m_f; i++)
            for (int j = 0; j < m_f; j++)
                sum += img[c][m_f*oy+i][m_f*opx+j];
        return (sum + (m_f*m_f)/2) / (m_f*m_f);
    endfunction

    function automatic bit completes(input int x, input int y);
        if ((x % m_f) != m_f - 1) return 1'b0;
        if (m_f == 1) return 1'b1;
        if (m_avg) return (y % m_f) == m_f - 1;
        return (y % m_f) == 0;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic push_expected(input int x, input int y);
        exp_t e;
        int   ox, oy;
        ox = x / m_f;
        oy = y / m_f;
        e.cyc = cyc + 2;
        e.x = ox;
        e.y = oy;
        for (int p = 0; p < 2; p++) begin
            e.r[p*8 +: 8] = 8'(model_pix(0, oy, 2*ox + p));
            e.g[p*8 +: 8] = 8'(model_pix(1, oy, 2*ox + p));
            e.b[p*8 +: 8] = 8'(model_pix(2, oy, 2*ox + p));
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input int x, input int y, input int gap_max);
        in_x     = 11'(x);
        in_y     = 11'(y);
        in_red   = {8'(img[0][y][2*x+1]), 8'(img[0][y][2*x])};
        in_green = {8'(img[1][y][2*x+1]), 8'(img[1][y][2*x])};
        in_blue  = {8'(img[2][y][2*x+1]), 8'(img[2][y][2*x])};
        in_valid = 1'b1;
        if (x == 0 && y == 0) begin
            m_armed = 1'b1;
            m_f     = fac(cfg_factor);
            m_avg   = cfg_mode;
        end
        if (m_armed && completes(x, y)) push_expected(x, y);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
    endtask

    task automatic feed_frame(input logic [1:0] cf, input logic md, input int gap_max,
                              input int change_line, input logic [1:0] cf2);
        cfg_factor = cf;
        cfg_mode   = md;
        for (int y = 0; y < H; y++) begin
            if (y == change_line) cfg_factor = cf2;
            for (int x = 0; x < BEATS; x++) drive_beat(x, y, gap_max);
        end
        idle(5);
        check("frame_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic do_reset(input int n);
        int k;
        k        = cyc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        m_armed  = 1'b0;
        while (q.size() > 0 && q[$].cyc > k) void'(q.pop_back());
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill_random();
        for (int c = 0; c < 3; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    img[c][y][x] = int'($urandom_range(255, 0));
    endtask

    task automatic clear_out_img();
        for (int c = 0; c < 3; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    out_img[c][y][x] = -1;
    endtask

    // Scoreboard: every output beat must match the next expected beat, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++;
            $display("FAIL missing_beat: no output seen, expected x=%0d y=%0d at cycle %0d",
                     q[0].x, q[0].y, q[0].cyc);
            void'(q.pop_front());
        end
        if (out_valid) begin
            n_out++;
            n_checks++;
            if (out_y < 11'(H) && out_x < 11'(BEATS)) begin
                for (int p = 0; p < 2; p++) begin
                    out_img[0][out_y][2*out_x+p] = int'(out_red[p*8 +: 8]);
                    out_img[1][out_y][2*out_x+p] = int'(out_green[p*8 +: 8]);
                    out_img[2][out_y][2*out_x+p] = int'(out_blue[p*8 +: 8]);
                end
            end
            if (q.size() == 0) begin
                $display("FAIL unexpected_beat: got out_valid x=%0d y=%0d at cycle %0d, expected none",
                         out_x, out_y, cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc == cyc && int'(out_x) == e.x && int'(out_y) == e.y &&
                    out_red == e.r && out_green == e.g && out_blue == e.b) begin
                    n_pass++;
                end else begin
                    $display("FAIL beat: got cyc=%0d x=%0d y=%0d rgb=%h/%h/%h, expected cyc=%0d x=%0d y=%0d rgb=%h/%h/%h",
                             cyc, out_x, out_y, out_red, out_green, out_blue,
                             e.cyc, e.x, e.y, e.r, e.g, e.b);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[13];
        int   n0, f;

        vecs[0]  = '{2'd2, 1'b1, 200, 215, 1, 5, 201};
        vecs[1]  = '{2'd1, 1'b1, 1, 0, 0, 0, 1};
        vecs[2]  = '{2'd1, 1'b1, 0, 255, 1, 1, 64};
        vecs[3]  = '{2'd2, 1'b1, 0, 7, 2, 2, 0};
        vecs[4]  = '{2'd2, 1'b1, 0, 8, 3, 3, 1};
        vecs[5]  = '{2'd1, 1'b0, 10, 99, 0, 2, 99};
        vecs[6]  = '{2'd1, 1'b0, 10, 99, 1, 2, 10};
        vecs[7]  = '{2'd2, 1'b0, 10, 99, 0, 4, 99};
        vecs[8]  = '{2'd2, 1'b0, 10, 99, 0, 5, 10};
        vecs[9]  = '{2'd0, 1'b1, 5, 77, 2, 3, 77};
        vecs[10] = '{2'd3, 1'b0, 10, 99, 2, 6, 99};
        vecs[11] = '{2'd2, 1'b1, 255, 255, 0, 0, 255};
        vecs[12] = '{2'd1, 1'b1, 100, 103, 2, 14, 101};

        rst_n      = 1'b0;
        cfg_factor = 2'd0;
        cfg_mode   = 1'b0;
        in_x       = 11'd0;
        in_y       = 11'd0;
        in_red     = 16'd0;
        in_green   = 16'd0;
        in_blue    = 16'd0;
        in_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_xy", int'({out_x, out_y}), 0);
        check("reset_out_rgb", int'(out_red | out_green | out_blue), 0);

        // Beats before any frame start must not produce output.
        fill_random();
        cfg_factor = 2'd0;
        for (int x = 0; x < BEATS; x++) drive_beat(x, 1, 0);
        idle(4);
        check("unarmed_silent", n_out, 0);

        // 1x NN ramp: passthrough of every beat.
        for (int c = 0; c < 3; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    img[c][y][x] = (y*W + x + 40*c) & 255;
        n0 = n_out;
        feed_frame(2'd0, 1'b0, 0, -1, 2'd0);
        check("ramp_1x_beats", n_out - n0, 32);

        // 2x NN with pixel = x coordinate.
        for (int c = 0; c < 3; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    img[c][y][x] = x;
        clear_out_img();
        n0 = n_out;
        feed_frame(2'd1, 1'b0, 0, -1, 2'd0);
        check("nn2x_beats", n_out - n0, 8);
        for (int k = 0; k < BEATS; k++) check("nn2x_pixel", out_img[0][1][k], 2*k);

        // Single-pixel perturbation vectors.
        foreach (vecs[i]) begin
            for (int c = 0; c < 3; c++)
                for (int y = 0; y < H; y++)
                    for (int x = 0; x < W; x++)
                        img[c][y][x] = vecs[i].base;
            for (int c = 0; c < 3; c++) img[c][vecs[i].py][vecs[i].px] = vecs[i].val;
            clear_out_img();
            feed_frame(vecs[i].factor, vecs[i].mode, 0, -1, 2'd0);
            f = fac(vecs[i].factor);
            check($sformatf("vec%0d_pixel", i), out_img[0][vecs[i].py/f][vecs[i].px/f], vecs[i].exp_val);
        end

        // Factor change mid-frame applies only from the next frame start.
        fill_random();
        n0 = n_out;
        feed_frame(2'd1, 1'b0, 0, 1, 2'd2);
        check("cfg_change_same_frame_beats", n_out - n0, 8);
        n0 = n_out;
        feed_frame(2'd2, 1'b0, 0, -1, 2'd2);
        check("cfg_change_next_frame_beats", n_out - n0, 2);

        // Reset during line 2, then the rest of that frame must stay silent.
        fill_random();
        cfg_factor = 2'd1;
        cfg_mode   = 1'b1;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < BEATS; x++) drive_beat(x, y, 1);
        for (int x = 0; x < 3; x++) drive_beat(x, 2, 0);
        do_reset(3);
        n0 = n_out;
        for (int x = 3; x < BEATS; x++) drive_beat(x, 2, 2);
        for (int x = 0; x < BEATS; x++) drive_beat(x, 3, 2);
        idle(4);
        check("post_reset_silent", n_out - n0, 0);
        fill_random();
        n0 = n_out;
        feed_frame(2'd2, 1'b1, 3, -1, 2'd2);
        check("post_reset_frame_beats", n_out - n0, 2);

        // Randomized frames with gaps.
        for (int i = 0; i < 8; i++) begin
            fill_random();
            feed_frame(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                       int'($urandom_range(3, 0)), -1, 2'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
